// File: rtl/div_unit_pkg.sv
// Shared constants and helpers for the EX-stage multi-cycle divider.
// State encodings and handshake levels are common to EX/ctrl and div_unit.
package div_unit_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic        RstEnable         = 1'b1;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Two's-complement negate when en is set; 0x80000000 maps to itself,
    // which is the correct 32-bit unsigned magnitude of INT_MIN.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        logic [31:0] r;
        if (en) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider answering the EX-stage start/ready handshake.
// Produces {remainder, quotient} for the HI/LO write after WIDTH iterations plus a sign fix-up.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signed_div_i,
    input  logic [RegBus-1:0]         opdata1_i,
    input  logic [RegBus-1:0]         opdata2_i,
    input  logic                      start_i,
    input  logic                      annul_i,
    output logic [DoubleRegBus-1:0]   result_o,
    output logic                      ready_o
);

    div_state_e        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [63:0]       work_q, work_d;     // {partial remainder, dividend/quotient bits}
    logic [31:0]       divisor_q, divisor_d;
    logic              signed_q, signed_d;
    logic              sign1_q, sign1_d;
    logic              sign2_q, sign2_d;
    logic              ready_q, ready_d;
    logic [63:0]       result_q, result_d;

    logic [32:0]       trial_s;
    logic              fits_s;
    logic [31:0]       rem_next_s;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        trial_s    = work_q[63:31];
        fits_s     = (trial_s >= {1'b0, divisor_q});
        if (fits_s) begin
            rem_next_s = trial_s[31:0] - divisor_q;
        end else begin
            rem_next_s = trial_s[31:0];
        end
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        ready_d   = DivResultNotReady;
        result_d  = {ZeroWord, ZeroWord};

        case (state_q)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    signed_d  = signed_div_i;
                    sign1_d   = opdata1_i[31];
                    sign2_d   = opdata2_i[31];
                    divisor_d = neg_if(opdata2_i, signed_div_i && opdata2_i[31]);
                    cnt_d     = 6'd0;
                    if (opdata2_i == ZeroWord) begin
                        state_d = DivByZero;
                        work_d  = 64'd0;
                    end else begin
                        state_d = DivOn;
                        work_d  = {ZeroWord, neg_if(opdata1_i, signed_div_i && opdata1_i[31])};
                    end
                end else begin
                    state_d = DivFree;
                end
            end
            DivByZero: begin
                if (annul_i || start_i == DivStop) begin
                    state_d = DivFree;
                end else begin
                    state_d = DivEnd;
                    work_d  = 64'd0;
                end
            end
            DivOn: begin
                if (annul_i || start_i == DivStop) begin
                    state_d = DivFree;
                    cnt_d   = 6'd0;
                end else if (cnt_q != 6'(WIDTH)) begin
                    cnt_d  = cnt_q + 6'd1;
                    work_d = {rem_next_s, work_q[30:0], fits_s};
                end else begin
                    // Magnitudes are done; restore signs (remainder follows the dividend).
                    work_d  = {neg_if(work_q[63:32], signed_q && sign1_q),
                               neg_if(work_q[31:0],  signed_q && (sign1_q ^ sign2_q))};
                    state_d = DivEnd;
                    cnt_d   = 6'd0;
                end
            end
            DivEnd: begin
                if (start_i == DivStart) begin
                    state_d  = DivEnd;
                    ready_d  = DivResultReady;
                    result_d = work_q;
                end else begin
                    state_d = DivFree;
                end
            end
            default: begin
                state_d = DivFree;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q   <= DivFree;
            cnt_q     <= 6'd0;
            work_q    <= 64'd0;
            divisor_q <= ZeroWord;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            ready_q   <= DivResultNotReady;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table for full divides plus annul/reset sequences.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total;
    int bad;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: issue a request, scramble operands after acceptance,
    // wait for ready, check latency/result, annul in END, then drop start.
    task automatic do_div(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        logic got;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~sgn;
            end
            if (ready_o === 1'b1) got = 1'b1;
        end
        chk({name, "_latency"}, 64'(n - 1), 64'(lat));
        chk({name, "_result"}, result_o, exp);
        annul_i = 1'b1;
        @(negedge clk);
        chk({name, "_end_annul_ready"}, 64'(ready_o), 64'd1);
        chk({name, "_end_hold"}, result_o, exp);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk({name, "_drop_ready"}, 64'(ready_o), 64'd0);
        chk({name, "_drop_result"}, result_o, 64'd0);
    endtask

    initial begin
        logic seen_ready;
        total = 0;
        bad   = 0;

        vecs[0] = '{"u100_7",     1'b0, 32'd100,        32'd7,        {32'd2, 32'd14},                  34};
        vecs[1] = '{"s_m7_2",     1'b1, 32'hFFFF_FFF9,  32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34};
        vecs[2] = '{"s_7_m2",     1'b1, 32'h0000_0007,  32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 34};
        vecs[3] = '{"byzero",     1'b0, 32'h1234_5678,  32'h0000_0000, 64'h0,                           2};
        vecs[4] = '{"u_max_1",    1'b0, 32'hFFFF_FFFF,  32'h0000_0001, {32'h0, 32'hFFFF_FFFF},         34};
        vecs[5] = '{"s_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0, 32'h8000_0000},         34};
        vecs[6] = '{"u_ovf_ops",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF, {32'h8000_0000, 32'h0},         34};
        vecs[7] = '{"s_m100_m7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E}, 34};
        vecs[8] = '{"s_min_2",    1'b1, 32'h8000_0000,  32'h0000_0002, {32'h0, 32'hC000_0000},         34};
        vecs[9] = '{"s_byzero",   1'b1, 32'hFFFF_FFFB,  32'h0000_0000, 64'h0,                           2};

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Annul at counter=10, then an immediate new request 9/3.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        seen_ready   = 1'b0;
        repeat (11) begin
            @(negedge clk);
            if (ready_o !== 1'b0) seen_ready = 1'b1;
        end
        annul_i = 1'b1;
        @(negedge clk);
        if (ready_o !== 1'b0) seen_ready = 1'b1;
        chk("annul_ready_never", 64'(seen_ready), 64'd0);
        chk("annul_result", result_o, 64'd0);
        annul_i = 1'b0;
        do_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

        // Reset at counter=20, then 0xFFFF / 0x100.
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0001_2345;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(ready_o), 64'd0);
        chk("midrst_result", result_o, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk("postrst_idle_ready", 64'(ready_o), 64'd0);
        do_div("after_rst_ffff_100", 1'b0, 32'h0000_FFFF, 32'h0000_0100, {32'hFF, 32'hFF}, 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
